// File: rtl/bfly_r2_post_pkg.sv
// Shared FFT Q-format constants and fixed-point helpers, used by the butterfly
// post-processing block and the complex multiplier.
package bfly_r2_post_pkg;

  localparam int unsigned DW     = 18;
  localparam int unsigned FRAC_W = 17;
  localparam int unsigned ACC_W  = 48;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(131071);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-131072);

  typedef struct packed {
    logic              sat;
    logic signed [DW-1:0] val;
  } sat18_t;

  // Clamp a wide signed value into Q1.17, flagging when clamping happened
  function automatic sat18_t sat18(input logic signed [ACC_W-1:0] v);
    sat18_t res;
    res.sat = 1'b0;
    res.val = v[DW-1:0];
    if (v > SAT_HI) begin
      res.sat = 1'b1;
      res.val = SAT_HI[DW-1:0];
    end else if (v < SAT_LO) begin
      res.sat = 1'b1;
      res.val = SAT_LO[DW-1:0];
    end
    return res;
  endfunction

  // Round-half-up then arithmetic shift; one guard bit absorbs the rounding carry
  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] v,
                                                          input int unsigned frac);
    logic signed [ACC_W:0] half;
    logic signed [ACC_W:0] t;
    half = (ACC_W+1)'(1) << (frac - 1);
    t    = $signed({v[ACC_W-1], v}) + half;
    return ACC_W'(t >>> frac);
  endfunction

  // Butterfly halving: (s + 1) >>> 1 on a 20-bit sum, then clamp
  function automatic sat18_t half_sat(input logic signed [DW+1:0] s);
    logic signed [DW+1:0] r;
    r = (s + (DW+2)'(1)) >>> 1;
    return sat18(ACC_W'(r));
  endfunction

endpackage

// File: rtl/bfly_r2_post_sync_fifo.sv
// Circular FIFO aligning X operands with multiplier products; supports
// simultaneous push/pop, including write-to-read bypass when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  output logic [WIDTH-1:0]           rd_data_c,
  output logic                       full_c,
  output logic                       empty_c,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             bypass_c, push_eff_c, pop_eff_c;

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;

  // Pop frees a slot before the push lands; an empty pop only advances when bypassing
  always_comb begin
    bypass_c   = push_i & pop_i & empty_c;
    push_eff_c = push_i & (~full_c | pop_i);
    pop_eff_c  = pop_i & (~empty_c | push_i);
    wr_ptr_d   = push_eff_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop_eff_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push_eff_c) - CNT_W'(pop_eff_c);
    rd_data_c  = mem_q[rd_ptr_q];
    if (empty_c) rd_data_c = bypass_c ? wr_data_i : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff_c) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/bfly_r2_post.sv
// Radix-2 butterfly back end: aligns X with the W*B product, rounds the product
// to Q1.17, then forms (X+P)/2 and (X-P)/2 with sticky error reporting.
module bfly_r2_post
  import bfly_r2_post_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned FRAC  = FRAC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_u1_x_valid,
  input  logic signed [DW-1:0]    i_s18_XR,
  input  logic signed [DW-1:0]    i_s18_XI,
  input  logic                    i_u1_prod_valid,
  input  logic signed [ACC_W-1:0] i_s48_PR,
  input  logic signed [ACC_W-1:0] i_s48_PI,
  input  logic                    i_u1_clr_err,
  output logic                    o_u1_valid_out,
  output logic signed [DW-1:0]    o_s18_Y0R,
  output logic signed [DW-1:0]    o_s18_Y0I,
  output logic signed [DW-1:0]    o_s18_Y1R,
  output logic signed [DW-1:0]    o_s18_Y1I,
  output logic                    o_u1_sat,
  output logic                    o_u1_ovf,
  output logic                    o_u1_unf
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [2*DW-1:0]  fifo_rd_c;
  logic             fifo_full_c, fifo_empty_c;
  logic [CNT_W-1:0] fifo_count;

  sync_fifo #(.WIDTH(2*DW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (i_u1_x_valid),
    .pop_i     (i_u1_prod_valid),
    .wr_data_i ({i_s18_XR, i_s18_XI}),
    .rd_data_c (fifo_rd_c),
    .full_c    (fifo_full_c),
    .empty_c   (fifo_empty_c),
    .count_o   (fifo_count)
  );

  logic                 s1_valid_q;
  logic signed [DW-1:0] s1_xr_q, s1_xi_q, s1_pr_q, s1_pi_q;
  logic                 valid_q;
  logic signed [DW-1:0] y0r_q, y0i_q, y1r_q, y1i_q;
  logic                 sat_q, sat_d, ovf_q, ovf_d, unf_q, unf_d;

  sat18_t p1r_c, p1i_c;
  sat18_t y0r_c, y0i_c, y1r_c, y1i_c;
  logic   sat1_c, sat2_c, ovf_evt_c, unf_evt_c;

  // Stage-1 product rounding and stage-2 butterfly arithmetic
  always_comb begin
    p1r_c = sat18(round_shift(i_s48_PR, FRAC));
    p1i_c = sat18(round_shift(i_s48_PI, FRAC));
    y0r_c = half_sat((DW+2)'(s1_xr_q) + (DW+2)'(s1_pr_q));
    y0i_c = half_sat((DW+2)'(s1_xi_q) + (DW+2)'(s1_pi_q));
    y1r_c = half_sat((DW+2)'(s1_xr_q) - (DW+2)'(s1_pr_q));
    y1i_c = half_sat((DW+2)'(s1_xi_q) - (DW+2)'(s1_pi_q));
  end

  // Error events; a simultaneous push/pop never over- or underflows
  always_comb begin
    sat1_c    = i_u1_prod_valid & (p1r_c.sat | p1i_c.sat);
    sat2_c    = s1_valid_q & (y0r_c.sat | y0i_c.sat | y1r_c.sat | y1i_c.sat);
    ovf_evt_c = i_u1_x_valid & fifo_full_c & ~i_u1_prod_valid;
    unf_evt_c = i_u1_prod_valid & fifo_empty_c & ~i_u1_x_valid;
    sat_d     = (sat1_c | sat2_c) ? 1'b1 : (i_u1_clr_err ? 1'b0 : sat_q);
    ovf_d     = ovf_evt_c         ? 1'b1 : (i_u1_clr_err ? 1'b0 : ovf_q);
    unf_d     = unf_evt_c         ? 1'b1 : (i_u1_clr_err ? 1'b0 : unf_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_xr_q    <= '0;
      s1_xi_q    <= '0;
      s1_pr_q    <= '0;
      s1_pi_q    <= '0;
      valid_q    <= 1'b0;
      y0r_q      <= '0;
      y0i_q      <= '0;
      y1r_q      <= '0;
      y1i_q      <= '0;
      sat_q      <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      s1_valid_q <= i_u1_prod_valid;
      if (i_u1_prod_valid) begin
        s1_xr_q <= fifo_rd_c[2*DW-1:DW];
        s1_xi_q <= fifo_rd_c[DW-1:0];
        s1_pr_q <= p1r_c.val;
        s1_pi_q <= p1i_c.val;
      end
      valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        y0r_q <= y0r_c.val;
        y0i_q <= y0i_c.val;
        y1r_q <= y1r_c.val;
        y1i_q <= y1i_c.val;
      end
      sat_q <= sat_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Occupancy counter and full flag must agree
  always_ff @(posedge clk) begin
    if (rst_n) assert (fifo_full_c == (fifo_count == CNT_W'(DEPTH)));
  end

  assign o_u1_valid_out = valid_q;
  assign o_s18_Y0R      = y0r_q;
  assign o_s18_Y0I      = y0i_q;
  assign o_s18_Y1R      = y1r_q;
  assign o_s18_Y1I      = y1i_q;
  assign o_u1_sat       = sat_q;
  assign o_u1_ovf       = ovf_q;
  assign o_u1_unf       = unf_q;

endmodule
